dphy_lane_aligner: RTL and testbench

- Sits in the sys_clk domain directly after the per-lane D-PHY input deserialisers.
- Takes NUM_LANES raw, bit-unaligned 8-bit words (LSB first) and searches each lane for the HS sync byte at any of 8 bit offsets.
- Locks each lane's offset, then removes inter-lane skew of up to MAX_SKEW byte clocks.
- Presents byte-aligned, lane-aligned data with a single valid flag to the CSI-2 packet layer.

---
 rtl/dphy_lane_aligner_pkg.sv | 16 +
 rtl/dphy_lane_word_align.sv | 79 +++++++
 rtl/dphy_lane_aligner.sv | 119 +++++++++++
 tb/tb_dphy_lane_aligner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_lane_aligner_pkg.sv
// Shared types and constants for the D-PHY lane aligner.
// FSM encoding, default HS sync byte and lane byte width.
package dphy_lane_aligner_pkg;

    localparam int          LANE_W        = 8;
    localparam logic [7:0]  SYNC_WORD_DEF = 8'hB8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HUNT      = 3'd1,
        SKEW_WAIT = 3'd2,
        ACTIVE    = 3'd3,
        ERROR     = 3'd4
    } state_t;

endpackage

// File: rtl/dphy_lane_word_align.sv
// One lane: 16-bit bit window, sync hunt at offsets 0..7, offset/lock-time capture, skew delay line.
// Byte register is one cycle after the window; tap adds 0..DEPTH cycles. No backpressure.
module dphy_lane_word_align
    import dphy_lane_aligner_pkg::*;
#(
    parameter logic [LANE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                DEPTH     = 3
) (
    input  logic              sys_clk,
    input  logic              areset,
    input  logic              clr,
    input  logic              hunt,
    input  logic [LANE_W-1:0] din,
    input  logic [2:0]        skew_cnt,
    input  logic [2:0]        last_lock,
    output logic              hit,
    output logic              locked,
    output logic [2:0]        lock_cnt,
    output logic [LANE_W-1:0] tap_dat
);

    logic [LANE_W-1:0]   prev;
    logic [2*LANE_W-1:0] win;
    logic [2:0]          offset;
    logic [2:0]          hit_k;
    logic                any_match;
    logic [2:0]          tap;
    logic [LANE_W-1:0]   sr [0:DEPTH];

    assign win = {din, prev};

    // Scan from the top so the lowest matching offset is the one left standing.
    always_comb begin
        any_match = 1'b0;
        hit_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (win[k +: LANE_W] == SYNC_WORD) begin
                any_match = 1'b1;
                hit_k     = 3'(k);
            end
        end
    end

    assign hit = hunt && !locked && any_match;

    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) begin
            prev     <= '0;
            locked   <= 1'b0;
            offset   <= '0;
            lock_cnt <= '0;
            for (int j = 0; j <= DEPTH; j++) sr[j] <= '0;
        end else begin
            prev  <= din;
            sr[0] <= locked ? win[offset +: LANE_W] : '0;
            for (int j = 1; j <= DEPTH; j++) sr[j] <= sr[j-1];
            if (clr) begin
                locked   <= 1'b0;
                offset   <= '0;
                lock_cnt <= '0;
            end else if (hit) begin
                locked   <= 1'b1;
                offset   <= hit_k;
                lock_cnt <= skew_cnt;
            end
        end
    end

    // Early lanes wait longer so every lane's first payload byte lines up.
    assign tap = last_lock - lock_cnt;

    always_comb begin
        tap_dat = sr[0];
        for (int j = 0; j <= DEPTH; j++) begin
            if (tap == 3'(j)) tap_dat = sr[j];
        end
    end

endmodule

// File: rtl/dphy_lane_aligner.sv
// Byte- and lane-aligns NUM_LANES raw D-PHY words for the CSI-2 packet layer.
// First dout_valid at the edge ending Tlast+2; no backpressure, data always accepted.
module dphy_lane_aligner
    import dphy_lane_aligner_pkg::*;
#(
    parameter int                NUM_LANES = 2,
    parameter logic [LANE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                MAX_SKEW  = 3
) (
    input  logic                        sys_clk,
    input  logic                        areset,
    input  logic                        hs_active,
    input  logic [LANE_W*NUM_LANES-1:0] din,
    output logic [LANE_W*NUM_LANES-1:0] dout,
    output logic                        dout_valid,
    output logic [NUM_LANES-1:0]        lane_locked,
    output logic                        sync_err
);

    localparam int         DEPTH    = (NUM_LANES == 1) ? 0 : MAX_SKEW;
    localparam logic [2:0] SKEW_LIM = 3'(MAX_SKEW);

    state_t                      state;
    logic [2:0]                  skew_cnt;
    logic                        act_q;
    logic                        hunt;
    logic                        all_lock;
    logic [NUM_LANES-1:0]        hit;
    logic [2:0]                  lock_cnt [NUM_LANES];
    logic [2:0]                  last_lock;
    logic [LANE_W*NUM_LANES-1:0] taps;

    assign hunt     = (state == HUNT) || (state == SKEW_WAIT);
    assign all_lock = &(lane_locked | hit);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dphy_lane_word_align #(
            .SYNC_WORD (SYNC_WORD),
            .DEPTH     (DEPTH)
        ) u_lane (
            .sys_clk   (sys_clk),
            .areset    (areset),
            .clr       (!hs_active),
            .hunt      (hunt),
            .din       (din[g*LANE_W +: LANE_W]),
            .skew_cnt  (skew_cnt),
            .last_lock (last_lock),
            .hit       (hit[g]),
            .locked    (lane_locked[g]),
            .lock_cnt  (lock_cnt[g]),
            .tap_dat   (taps[g*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        last_lock = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (lock_cnt[n] > last_lock) last_lock = lock_cnt[n];
        end
    end

    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            skew_cnt   <= '0;
            act_q      <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            sync_err   <= 1'b0;
        end else if (!hs_active) begin
            state      <= IDLE;
            skew_cnt   <= '0;
            act_q      <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            // ACTIVE is entered one cycle before the last lane's first payload byte
            // reaches its byte register, so valid waits for a second ACTIVE cycle.
            act_q      <= (state == ACTIVE);
            dout_valid <= (state == ACTIVE) && act_q;
            dout       <= ((state == ACTIVE) && act_q) ? taps : '0;
            case (state)
                IDLE: begin
                    state    <= HUNT;
                    skew_cnt <= '0;
                end
                HUNT: begin
                    if (all_lock) begin
                        state <= ACTIVE;
                    end else if (|hit) begin
                        if (SKEW_LIM == 3'd0) begin
                            state    <= ERROR;
                            sync_err <= 1'b1;
                        end else begin
                            state    <= SKEW_WAIT;
                            skew_cnt <= 3'd1;
                        end
                    end
                end
                SKEW_WAIT: begin
                    if (all_lock) begin
                        state <= ACTIVE;
                    end else if (skew_cnt >= SKEW_LIM) begin
                        state    <= ERROR;
                        sync_err <= 1'b1;
                    end else begin
                        skew_cnt <= skew_cnt + 3'd1;
                    end
                end
                ACTIVE:  state <= ACTIVE;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_lane_aligner.sv
// Directed bench: 2-lane aligner (sync, skew, error, re-hunt, reset) and a 1-lane build.
// Raw bit streams are built per lane and sliced 8 bits per cycle, earliest bit in bit 0.
module tb_dphy_lane_aligner;

    logic        clk;
    logic        areset;
    logic        hs_active;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic [1:0]  lane_locked;
    logic        sync_err;

    logic        hs_active1;
    logic [7:0]  din1;
    logic [7:0]  dout1;
    logic        dout_valid1;
    logic [0:0]  lane_locked1;
    logic        sync_err1;

    int vectors = 0;
    int errs    = 0;

    bit q0[$];
    bit q1[$];
    bit q2[$];

    dphy_lane_aligner #(.NUM_LANES(2), .SYNC_WORD(8'hB8), .MAX_SKEW(3)) u_dut2 (
        .sys_clk     (clk),
        .areset      (areset),
        .hs_active   (hs_active),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .lane_locked (lane_locked),
        .sync_err    (sync_err)
    );

    dphy_lane_aligner #(.NUM_LANES(1), .SYNC_WORD(8'hB8), .MAX_SKEW(3)) u_dut1 (
        .sys_clk     (clk),
        .areset      (areset),
        .hs_active   (hs_active1),
        .din         (din1),
        .dout        (dout1),
        .dout_valid  (dout_valid1),
        .lane_locked (lane_locked1),
        .sync_err    (sync_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input int lane, input bit b);
        if (lane == 0)      q0.push_back(b);
        else if (lane == 1) q1.push_back(b);
        else                q2.push_back(b);
    endtask

    task automatic push_zeros(input int lane, input int n);
        for (int i = 0; i < n; i++) push_bit(lane, 1'b0);
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int i = 0; i < 8; i++) push_bit(lane, b[i]);
    endtask

    function automatic bit pop_bit(input int lane);
        bit b = 1'b0;
        if (lane == 0 && q0.size() > 0)      b = q0.pop_front();
        else if (lane == 1 && q1.size() > 0) b = q1.pop_front();
        else if (lane == 2 && q2.size() > 0) b = q2.pop_front();
        return b;
    endfunction

    task automatic flush();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Drive one word per lane, then sample just after the edge that consumes it.
    task automatic cyc();
        logic [7:0] w0, w1, w2;
        for (int i = 0; i < 8; i++) begin
            w0[i] = pop_bit(0);
            w1[i] = pop_bit(1);
            w2[i] = pop_bit(2);
        end
        din  = {w1, w0};
        din1 = w2;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_cycle();
        flush();
        hs_active = 1'b0;
        cyc();
        hs_active = 1'b1;
    endtask

    initial begin
        areset     = 1'b1;
        hs_active  = 1'b1;
        hs_active1 = 1'b0;
        din        = '0;
        din1       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",    dout, 16'h0000);
        chk("rst_valid",   {15'd0, dout_valid}, 16'd0);
        chk("rst_locked",  {14'd0, lane_locked}, 16'd0);
        chk("rst_err",     {15'd0, sync_err}, 16'd0);
        chk("rst1_valid",  {15'd0, dout_valid1}, 16'd0);
        areset    = 1'b0;
        hs_active = 1'b0;

        // Both lanes: sync at offset 3, zero skew; payload includes B8 shifted by 4 bits and B8 itself.
        clear_cycle();
        for (int l = 0; l < 2; l++) begin
            push_zeros(l, 19);
            push_byte(l, 8'hB8); push_byte(l, 8'h12); push_byte(l, 8'h34);
            push_byte(l, 8'h80); push_byte(l, 8'h0B); push_byte(l, 8'hB8);
        end
        run(4);
        chk("t1_locked",   {14'd0, lane_locked}, 16'h0003);
        chk("t1_valid_c3", {15'd0, dout_valid}, 16'd0);
        run(1);
        chk("t1_valid_c4", {15'd0, dout_valid}, 16'd0);
        run(1);
        chk("t1_valid_c5", {15'd0, dout_valid}, 16'd1);
        chk("t1_dout_12",  dout, 16'h1212);
        run(1);
        chk("t1_dout_34",  dout, 16'h3434);
        run(1);
        chk("t1_dout_80",  dout, 16'h8080);
        run(1);
        chk("t1_dout_0b",  dout, 16'h0B0B);
        run(1);
        chk("t1_dout_b8",  dout, 16'hB8B8);
        chk("t1_err",      {15'd0, sync_err}, 16'd0);

        // hs_active dropped mid-packet: lock and valid clear on that edge.
        clear_cycle();
        chk("hs_drop_valid",  {15'd0, dout_valid}, 16'd0);
        chk("hs_drop_locked", {14'd0, lane_locked}, 16'd0);
        chk("hs_drop_dout",   dout, 16'h0000);

        // Re-hunt at offset 7.
        for (int l = 0; l < 2; l++) begin
            push_zeros(l, 23);
            push_byte(l, 8'hB8); push_byte(l, 8'h81); push_byte(l, 8'h7E);
        end
        run(4);
        chk("t7_locked", {14'd0, lane_locked}, 16'h0003);
        run(2);
        chk("t7_valid",  {15'd0, dout_valid}, 16'd1);
        chk("t7_dout_81", dout, 16'h8181);
        run(1);
        chk("t7_dout_7e", dout, 16'h7E7E);

        // Asynchronous reset in the middle of a cycle while ACTIVE.
        #3;
        areset = 1'b1;
        #1;
        chk("arst_valid",  {15'd0, dout_valid}, 16'd0);
        chk("arst_dout",   dout, 16'h0000);
        chk("arst_locked", {14'd0, lane_locked}, 16'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Lane 1 locks 2 cycles after lane 0 (offsets 5 and 0).
        clear_cycle();
        push_zeros(0, 21); push_byte(0, 8'hB8); push_byte(0, 8'hA5);
        push_zeros(1, 32); push_byte(1, 8'hB8); push_byte(1, 8'hA5);
        run(4);
        chk("sk2_locked_c3", {14'd0, lane_locked}, 16'h0001);
        run(2);
        chk("sk2_locked_c5", {14'd0, lane_locked}, 16'h0003);
        chk("sk2_err_c5",    {15'd0, sync_err}, 16'd0);
        run(1);
        chk("sk2_valid_c6",  {15'd0, dout_valid}, 16'd0);
        run(1);
        chk("sk2_valid_c7",  {15'd0, dout_valid}, 16'd1);
        chk("sk2_dout_c7",   dout, 16'hA5A5);
        run(1);
        chk("sk2_dout_c8",   dout, 16'h0000);
        chk("sk2_err_c8",    {15'd0, sync_err}, 16'd0);

        // Lane 1 locks 4 cycles after lane 0: exceeds MAX_SKEW=3.
        clear_cycle();
        push_zeros(0, 19); push_byte(0, 8'hB8); push_byte(0, 8'h11);
        push_zeros(1, 48); push_byte(1, 8'hB8); push_byte(1, 8'h11);
        run(6);
        chk("sk4_err_c5",    {15'd0, sync_err}, 16'd0);
        run(1);
        chk("sk4_err_c6",    {15'd0, sync_err}, 16'd1);
        chk("sk4_valid_c6",  {15'd0, dout_valid}, 16'd0);
        run(1);
        chk("sk4_err_c7",    {15'd0, sync_err}, 16'd0);
        chk("sk4_valid_c7",  {15'd0, dout_valid}, 16'd0);
        chk("sk4_locked_c7", {14'd0, lane_locked}, 16'h0001);
        run(2);
        chk("sk4_valid_c9",  {15'd0, dout_valid}, 16'd0);

        // Recovery after one hs_active-low cycle: aligned sync at offset 6.
        clear_cycle();
        for (int l = 0; l < 2; l++) begin
            push_zeros(l, 22); push_byte(l, 8'hB8); push_byte(l, 8'h3C);
        end
        run(5);
        chk("rec_valid_c4", {15'd0, dout_valid}, 16'd0);
        run(1);
        chk("rec_valid_c5", {15'd0, dout_valid}, 16'd1);
        chk("rec_dout",     dout, 16'h3C3C);

        // Single-lane build: offset 0, then offset 7.
        flush();
        hs_active  = 1'b0;
        hs_active1 = 1'b1;
        push_zeros(2, 16); push_byte(2, 8'hB8); push_byte(2, 8'h6D);
        run(4);
        chk("l1_o0_locked", {15'd0, lane_locked1}, 16'd1);
        run(1);
        chk("l1_o0_valid_c4", {15'd0, dout_valid1}, 16'd0);
        run(1);
        chk("l1_o0_valid_c5", {15'd0, dout_valid1}, 16'd1);
        chk("l1_o0_dout",     {8'd0, dout1}, 16'h006D);

        flush();
        hs_active1 = 1'b0;
        cyc();
        chk("l1_clr_valid",  {15'd0, dout_valid1}, 16'd0);
        chk("l1_clr_locked", {15'd0, lane_locked1}, 16'd0);
        hs_active1 = 1'b1;
        push_zeros(2, 23); push_byte(2, 8'hB8); push_byte(2, 8'hC3);
        run(5);
        chk("l1_o7_valid_c4", {15'd0, dout_valid1}, 16'd0);
        run(1);
        chk("l1_o7_valid_c5", {15'd0, dout_valid1}, 16'd1);
        chk("l1_o7_dout",     {8'd0, dout1}, 16'h00C3);
        chk("l1_err",         {15'd0, sync_err1}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
